reg_file_mp: RTL and testbench

Parametrised multi-read-port register file for the MIPS datapath, successor to the fixed 32×32 two-port file.
- Adds configurable width, depth and read-port count, an optional hardwired-zero entry, and optional write-to-read bypass.
- Replaces the all-entries-at-once reset with a sequential clear engine that walks the array one entry per cycle, so the array can map onto RAM.
- Sits between decode (read addresses) and writeback (write port), with reads combinational as in the single-cycle core.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_clear_seq.sv | 59 +++++
 rtl/reg_file_mp.sv | 89 ++++++++
 tb/tb_reg_file_mp.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file.
//   rf_state_t : clear-engine state (CLEAR walks the array, RUN is normal use)
//   DEF_DATA_W / DEF_ADDR_W : default geometry (32 x 32)
//   rf_depth() : number of entries for a given address width
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  function automatic int unsigned rf_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Sequential clear engine: walks the array one entry per cycle after reset
// or a clear request, then hands the write port back to the datapath.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   clr           : restart the clear walk from entry 0
//   busy          : walk in progress (combinational from state)
//   clr_we        : write a zero to clr_addr on this edge
//   clr_addr      : entry being cleared
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  rf_state_t         r_state;
  logic [ADDR_W-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          if (clr) begin
            r_ptr <= '0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
            // DEPTH is a power of two, so the last entry is all-ones
            if (&r_ptr) r_state <= RUN;
          end
        end
        RUN: begin
          if (clr) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_ptr   <= '0;
        end
      endcase
    end
  end

  assign busy     = (r_state == CLEAR);
  // The restart edge and the reset edge do not write the array
  assign clr_we   = (r_state == CLEAR) && !rst && !clr;
  assign clr_addr = r_ptr;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-read-port register file with sequential clear.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : request full-array clear (pulse)
//   rd_addr   : NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data   : NUM_RD packed read data, port k at [k*DATA_W +: DATA_W]
//   we, wr_addr, wr_data : write port
//   busy      : clear engine active; writes ignored, reads return 0
//   wr_drop   : registered pulse, a write was discarded the previous cycle
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     busy,
  output logic                     wr_drop
);

  localparam int unsigned DEPTH = rf_depth(ADDR_W);

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_zero_hit;
  logic              w_run_we;
  logic              r_wr_drop;
  logic [DATA_W-1:0] r_mem [DEPTH];

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (w_busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  assign w_zero_hit = (ZERO_REG != 0) && (wr_addr == '0);
  assign w_run_we   = we && !w_busy && !clr && !w_zero_hit;

  always_ff @(posedge clk) begin
    if (rst) r_wr_drop <= 1'b0;
    else     r_wr_drop <= we && !w_run_we;
  end

  // Array has no reset of its own so it can map onto RAM; the clear engine
  // and the run-mode write share a single write port (mutually exclusive).
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clr_we)      r_mem[w_clr_addr] <= '0;
      else if (w_run_we) r_mem[wr_addr]    <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;

    assign w_ra = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      w_rd = '0;
      if (w_busy)                                   w_rd = '0;
      else if ((ZERO_REG != 0) && (w_ra == '0))     w_rd = '0;
      else if ((BYPASS != 0) && we && (wr_addr == w_ra)) w_rd = wr_data;
      else                                          w_rd = r_mem[w_ra];
    end

    assign rd_data[k*DATA_W +: DATA_W] = w_rd;
  end

  assign busy    = w_busy;
  assign wr_drop = r_wr_drop;

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT a: ZERO_REG=1 BYPASS=1 ; DUT b: ZERO_REG=0 BYPASS=0 (shared stimulus)
  logic        rst, clr, we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [9:0]  ra;
  logic [63:0] rd_a, rd_b;
  logic        busy_a, busy_b, drop_a, drop_b;

  // DUT c: 4 ports, 16-bit, 8 entries
  logic        clr_c, we_c;
  logic [2:0]  wa_c;
  logic [15:0] wd_c;
  logic [11:0] ra_c;
  logic [63:0] rd_c;
  logic        busy_c, drop_c;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .rd_addr(ra), .rd_data(rd_a), .we(we),
    .wr_addr(wa), .wr_data(wd), .busy(busy_a), .wr_drop(drop_a));

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .clr(clr), .rd_addr(ra), .rd_data(rd_b), .we(we),
    .wr_addr(wa), .wr_data(wd), .busy(busy_b), .wr_drop(drop_b));

  reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) u_c (
    .clk(clk), .rst(rst), .clr(clr_c), .rd_addr(ra_c), .rd_data(rd_c), .we(we_c),
    .wr_addr(wa_c), .wr_data(wd_c), .busy(busy_c), .wr_drop(drop_c));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0, ra1;
    logic [31:0] a0, a1, b0, b1;
    logic        da, db;
  } vec_t;

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [11:0] ra;
    logic [63:0] exp;
    logic        drop;
  } cvec_t;

  // Runs until busy_a falls (bounded). Reads during the walk must be 0;
  // a write to r3 is attempted at step write_at and must be dropped.
  task automatic wait_idle(input int start, input int write_at, output int n);
    n = start;
    while (busy_a && n < 200) begin
      @(negedge clk);
      we = (n == write_at);
      wa = 5'd3;
      wd = 32'h55;
      #1;
      chk($sformatf("busy read a n=%0d", n), rd_a, 64'h0);
      chk($sformatf("busy read b n=%0d", n), rd_b, 64'h0);
      @(posedge clk);
      n++;
      #1;
      chk($sformatf("walk drop a n=%0d", n), drop_a, (n == write_at + 1));
      chk($sformatf("walk drop b n=%0d", n), drop_b, (n == write_at + 1));
    end
    we = 1'b0;
  endtask

  vec_t  vt[9];
  cvec_t ct[4];

  initial begin
    int na, nb, nc, n;

    vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
    vt[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    vt[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    vt[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h12345678, 32'h12345678, 1'b0, 1'b0};
    vt[4] = '{1'b1, 5'd6,  32'hCAFEF00D, 5'd6,  5'd5,  32'hCAFEF00D, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    vt[5] = '{1'b1, 5'd5,  32'h11111111, 5'd5,  5'd6,  32'h11111111, 32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b0};
    vt[6] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd6,  32'h11111111, 32'hCAFEF00D, 32'h11111111, 32'hCAFEF00D, 1'b0, 1'b0};
    vt[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
    vt[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd0,  32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b0};

    ct[0] = '{1'b0, 3'd0, 16'h0,    {3'd3, 3'd2, 3'd1, 3'd0}, {16'h3333, 16'h2222, 16'h1111, 16'h0000}, 1'b0};
    ct[1] = '{1'b0, 3'd0, 16'h0,    {3'd5, 3'd5, 3'd5, 3'd5}, {16'h5555, 16'h5555, 16'h5555, 16'h5555}, 1'b0};
    ct[2] = '{1'b1, 3'd4, 16'hABCD, {3'd4, 3'd4, 3'd7, 3'd0}, {16'hABCD, 16'hABCD, 16'h7777, 16'h0000}, 1'b0};
    ct[3] = '{1'b1, 3'd0, 16'hFFFF, {3'd0, 3'd0, 3'd4, 3'd6}, {16'h0000, 16'h0000, 16'hABCD, 16'h6666}, 1'b1};

    rst = 1'b1; clr = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = '0;
    clr_c = 1'b0; we_c = 1'b0; wa_c = '0; wd_c = '0; ra_c = '0;

    // ---- reset state and clear walk length
    @(negedge clk);
    chk("reset busy a", busy_a, 1'b1);
    chk("reset busy c", busy_c, 1'b1);
    chk("reset drop a", drop_a, 1'b0);
    chk("reset drop c", drop_c, 1'b0);
    chk("reset rd a", rd_a, 64'h0);
    chk("reset rd c", rd_c, 64'h0);
    rst = 1'b0;
    n = 0; na = 0; nb = 0; nc = 0;
    while ((busy_a || busy_b || busy_c) && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!busy_a && na == 0) na = n;
      if (!busy_b && nb == 0) nb = n;
      if (!busy_c && nc == 0) nc = n;
    end
    chk("reset walk a", na, 32);
    chk("reset walk b", nb, 32);
    chk("reset walk c", nc, 8);

    for (int i = 0; i < 32; i++) begin
      ra = {5'(31 - i), 5'(i)};
      #1;
      chk($sformatf("cleared a r%0d", i), rd_a, 64'h0);
      chk($sformatf("cleared b r%0d", i), rd_b, 64'h0);
    end

    // ---- write / read vectors (bypass, zero register)
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      we = vt[i].we; wa = vt[i].wa; wd = vt[i].wd; ra = {vt[i].ra1, vt[i].ra0};
      #1;
      chk($sformatf("vec%0d a rd0", i), rd_a[31:0],  vt[i].a0);
      chk($sformatf("vec%0d a rd1", i), rd_a[63:32], vt[i].a1);
      chk($sformatf("vec%0d b rd0", i), rd_b[31:0],  vt[i].b0);
      chk($sformatf("vec%0d b rd1", i), rd_b[63:32], vt[i].b1);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d a drop", i), drop_a, vt[i].da);
      chk($sformatf("vec%0d b drop", i), drop_b, vt[i].db);
    end
    we = 1'b0;

    // ---- multi-port DUT
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      we_c = 1'b1; wa_c = 3'(i); wd_c = 16'(i * 16'h1111);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      we_c = ct[i].we; wa_c = ct[i].wa; wd_c = ct[i].wd; ra_c = ct[i].ra;
      #1;
      chk($sformatf("cvec%0d rd", i), rd_c, ct[i].exp);
      @(posedge clk);
      #1;
      chk($sformatf("cvec%0d drop", i), drop_c, ct[i].drop);
    end
    we_c = 1'b0;

    // ---- clear mid-operation with a simultaneous write to r7
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      we = 1'b1; wa = 5'(i); wd = 32'(i);
    end
    @(negedge clk);
    we = 1'b0; ra = {5'd1, 5'd7};
    #1;
    chk("fill a r7", rd_a[31:0], 32'd7);
    chk("fill b r1", rd_b[63:32], 32'd1);
    @(negedge clk);
    clr = 1'b1; we = 1'b1; wa = 5'd7; wd = 32'hAA;
    @(posedge clk);
    #1;
    clr = 1'b0; we = 1'b0;
    chk("clr busy a", busy_a, 1'b1);
    chk("clr drop a", drop_a, 1'b1);
    chk("clr drop b", drop_b, 1'b1);
    ra = {5'd3, 5'd7};
    wait_idle(0, -1, n);
    chk("clr walk length", n, 32);
    @(negedge clk);
    ra = {5'd1, 5'd7};
    #1;
    chk("post clr a", rd_a, 64'h0);
    chk("post clr b", rd_b, 64'h0);

    // ---- clr restart at walk step 10, write attempted late in the walk
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    for (int i = 0; i < 10; i++) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("restart busy", busy_a, 1'b1);
    ra = {5'd3, 5'd7};
    wait_idle(0, 20, n);
    chk("restart walk length", n, 32);
    @(negedge clk);
    ra = {5'd3, 5'd3};
    #1;
    chk("busy write a r3", rd_a, 64'h0);
    chk("busy write b r3", rd_b, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
